// File: rtl/pc_pkg.sv
// Shared fetch/control definitions: next-PC select encodings and default PC geometry.
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_RET    = 2'b11
    } sel_t;

    localparam int PC_XLEN = 32;
    localparam int PC_STEP = 4;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push, pop or replace-top in one cycle; a push when full overwrites the oldest entry.
// Latency: top/empty/full are combinational from state; ovf/unf are registered 1-cycle pulses.
module ras_stack #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [CW-1:0]   count;

    // ptr is the next write slot; when full it lands on the oldest entry
    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            unf <= 1'b0;
            if (push && pop && !empty) begin
                mem[top_idx] <= wdata;
            end else if (push) begin
                mem[ptr] <= wdata;
                ptr      <= ptr + PW'(1);
                if (full) ovf <= 1'b1;
                else      count <= count + CW'(1);
                unf <= pop;
            end else if (pop) begin
                if (empty) begin
                    unf <= 1'b1;
                end else begin
                    ptr   <= ptr - PW'(1);
                    count <= count - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch program counter with seq/branch/jump/return selection, forced alignment and a call/return stack.
// Latency: pc_out updates one clock after an ena=1 edge; pc_plus and ras_top are combinational.
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int              XLEN      = PC_XLEN,
    parameter int              STEP      = PC_STEP,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              DEPTH     = 4,
    parameter int              ALIGN     = 2
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            ena,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] offset,
    input  logic [XLEN-1:0] target,
    input  logic            call,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            misalign,
    output logic            ras_ovf,
    output logic            ras_unf
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN);

    sel_t            sel_e;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] raw_next;

    assign sel_e   = sel_t'(sel);
    assign push    = ena & call;
    assign pop     = ena & (sel_e == SEL_RET);
    assign pc_plus = pc_out + XLEN'(STEP);

    always_comb begin
        raw_next = pc_plus;
        case (sel_e)
            SEL_SEQ:    raw_next = pc_plus;
            SEL_BRANCH: raw_next = pc_out + offset;
            SEL_JUMP:   raw_next = target;
            SEL_RET:    raw_next = ras_empty ? pc_plus : ras_top;
            default:    raw_next = pc_plus;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pc_out   <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            misalign <= 1'b0;
            if (ena) begin
                pc_out   <= raw_next & ~ALIGN_MASK;
                misalign <= |(raw_next & ALIGN_MASK);
            end
        end
    end

    // Return address is the unaligned pc_out+STEP; it stays aligned as long as pc_out is
    ras_stack #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk   (clk),
        .clr_n (clr_n),
        .push  (push),
        .pop   (pop),
        .wdata (pc_plus),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised program counter for the RISC-V fetch stage. It is the successor to the 4-bit incrementing PC and adds configurable width, step, and reset vector. Next-PC selection covers sequential, PC-relative branch, absolute jump and return. A circular return-address stack (RAS) handles call/return prediction. It sits between the control unit, which drives select/call/enable, and instruction memory, which consumes pc_out.

Parameters:
XLEN, 32, PC and offset width in bits
STEP, 4, sequential increment in bytes
RESET_VEC, 0, pc_out value after reset (XLEN bits)
DEPTH, 4, RAS entries (power of 2, >=2)
ALIGN, 2, number of low PC bits that must be zero

Ports:
clk  in  1  rising-edge clock
clr_n  in  1  asynchronous active-low reset
ena  in  1  advance enable; 0 = stall, all state holds
sel  in  2  next-PC select: 00 SEQ, 01 BRANCH (pc_out+offset), 10 JUMP (target), 11 RET (pop RAS)
offset  in  XLEN  signed two's-complement branch offset
target  in  XLEN  absolute jump target
call  in  1  push return address (pc_out+STEP) this cycle
pc_out  out  XLEN  current PC (registered)
pc_plus  out  XLEN  combinational pc_out+STEP
ras_top  out  XLEN  combinational top-of-stack value (0 when empty)
ras_empty  out  1  RAS count == 0
ras_full  out  1  RAS count == DEPTH
misalign  out  1  registered 1-cycle pulse: selected next PC had nonzero low ALIGN bits
ras_ovf  out  1  registered 1-cycle pulse: push onto full stack
ras_unf  out  1  registered 1-cycle pulse: RET on empty stack

Behaviour:
- Reset (clr_n=0, async, no clock needed): pc_out=RESET_VEC, RAS count=0, pointer=0, entries=0, misalign/ras_ovf/ras_unf=0. The first update occurs on the first rising clk after clr_n rises.
- ena=0: pc_out, RAS and count hold; sel/call ignored; pulse outputs 0 next cycle.
- ena=1, next PC computed per sel; all arithmetic is modulo 2^XLEN (wraps silently, no flag):
  - SEQ: pc_out+STEP.
  - BRANCH: pc_out+offset.
  - JUMP: target.
  - RET, non-empty: ras_top; count decrements.
  - RET, empty: pc_out+STEP; ras_unf=1.
- Alignment: if next PC[ALIGN-1:0]!=0, the low ALIGN bits are forced to 0 before registering and misalign=1. It applies to all sel values.
- Latency: pc_out reflects the selection one clock after the ena=1 edge. pc_plus and ras_top are combinational from registered state.
- call=1 with ena=1: push pc_out+STEP (unaligned value as computed, always aligned if pc_out is aligned).
  - Push on full: overwrite the oldest entry (circular), count stays DEPTH, ras_ovf=1.
- call=1 and sel=RET in the same cycle:
  - Non-empty: next PC = current top; top entry replaced by pc_out+STEP; count unchanged; no ovf/unf.
  - Empty: next PC = pc_out+STEP; push happens (count=1); ras_unf=1.
- call with sel=SEQ/BRANCH/JUMP: push and PC update occur independently in the same edge.
- Reset asserted mid-operation: immediately returns to reset state; stack contents discarded.

Decomposition:
- Shared package pc_pkg: sel encodings (SEL_SEQ, SEL_BRANCH, SEL_JUMP, SEL_RET) and the default XLEN/STEP constants used by fetch and control.
- One sub-module, ras_stack: circular DEPTH x XLEN storage, pointer, count, and push/pop/replace. Ports: clk, clr_n, push, pop, wdata, top, empty, full, ovf, unf.
- The PC register, next-PC mux and alignment logic stay in pc_ras_unit.

Test Plan:
All scenarios use XLEN=32, STEP=4, DEPTH=4, RESET_VEC=0, ALIGN=2.
1. Reset then 3 clocks ena=1 sel=SEQ -> pc_out 0,4,8,0xC. Assert clr_n=0 mid-clock -> pc_out=0 immediately, without waiting for clk.
2. pc_out=0x100, sel=BRANCH offset=0xFFFFFFF0 -> 0xF0. Then sel=JUMP target=0x2002 -> pc_out=0x2000 with misalign=1 for one cycle. Hold ena=0 for 3 clocks -> pc_out stays 0x2000.
3. Call chain: calls at pc 0x10,0x20,0x30,0x40 (sel=JUMP) -> ras_full=1. Fifth call at 0x50 -> ras_ovf=1, count stays 4. Then four RETs -> pc_out 0x54,0x44,0x34,0x24 -> ras_empty=1.
4. RET on empty at pc_out=0x80 -> pc_out=0x84, ras_unf=1, count 0.
5. Stack top=0x300, pc_out=0x500, call=1 and sel=RET together -> pc_out=0x300, ras_top=0x504, count unchanged.
6. Wrap: pc_out=0xFFFFFFFC, sel=SEQ -> pc_out=0x0, no flags asserted.
